// File: rtl/frame_draw_sequencer_pkg.sv
// Shared screen geometry, pixel types and sequencer state encoding for the
// frame draw sequencer and its tick generator.
package frame_draw_sequencer_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [7:0] pix_x_t;
  typedef logic [6:0] pix_y_t;
  typedef logic [2:0] colour_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_LATCH,
    SEQ_ERASE,
    SEQ_DRAW,
    SEQ_COLS
  } seq_state_t;

  // Widened coordinates so offsets that overflow 8/7 bits are still rejected.
  function automatic logic onScreen(input logic [8:0] px, input logic [7:0] py);
    return (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/frame_draw_sequencer_if.sv
// Game-object, column-engine and VGA-adapter signals of the frame draw sequencer.
// The sequencer takes the master modport; the game side takes the slave modport.
interface frame_draw_sequencer_if;
  import frame_draw_sequencer_pkg::*;

  pix_x_t  dot_x;
  pix_y_t  dot_y;
  colour_t dot_colour;
  pix_x_t  col_x;
  pix_y_t  col_y;
  colour_t col_colour;
  logic    col_valid;
  logic    col_done;
  logic    col_ready;
  logic    frame_tick;
  pix_x_t  x;
  pix_y_t  y;
  colour_t colour;
  logic    plot;
  logic    busy;
  logic    overrun;

  modport master (
    input  dot_x, dot_y, dot_colour,
    input  col_x, col_y, col_colour, col_valid, col_done,
    output col_ready, frame_tick,
    output x, y, colour, plot, busy, overrun
  );

  modport slave (
    output dot_x, dot_y, dot_colour,
    output col_x, col_y, col_colour, col_valid, col_done,
    input  col_ready, frame_tick,
    input  x, y, colour, plot, busy, overrun
  );

endinterface

// File: rtl/frame_draw_sequencer_frame_tick_gen.sv
// Free-running frame counter; pulses tick_o for one clock every CLK_HZ/FRAME_HZ clocks.
module frame_tick_gen #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int FRAME_HZ = 60
) (
  input  logic clk,
  input  logic resetn,
  output logic tick_o
);

  localparam int FRAME_DIV = CLK_HZ / FRAME_HZ;
  localparam int CW        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = (count_q == LAST_COUNT) ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/frame_draw_sequencer.sv
// Per-frame pixel sequencer: erases the old dot square, draws the new one, then
// hands the VGA adapter to the column engine until it reports done.
module frame_draw_sequencer
  import frame_draw_sequencer_pkg::*;
#(
  parameter int      CLK_HZ    = 50_000_000,
  parameter int      FRAME_HZ  = 60,
  parameter int      DOT_SIZE  = 2,
  parameter colour_t BG_COLOUR = 3'b000
) (
  input  logic                     clk,
  input  logic                     resetn,
  frame_draw_sequencer_if.master   bus
);

  localparam logic [3:0] LAST_IDX = 4'(DOT_SIZE * DOT_SIZE - 1);
  localparam logic [3:0] SIDE     = 4'(DOT_SIZE);

  seq_state_t state_q;
  logic [3:0] pixIdx_q;
  pix_x_t     newX_q, oldX_q;
  pix_y_t     newY_q, oldY_q;
  colour_t    newColour_q;
  logic       oldValid_q;

  pix_x_t     x_q, x_d;
  pix_y_t     y_q, y_d;
  colour_t    colour_q, colour_d;
  logic       plot_q, plot_d;

  logic       frameTick;
  logic       lastPix;
  pix_x_t     baseX;
  pix_y_t     baseY;
  logic [3:0] offX, offY;
  logic [8:0] sumX;
  logic [7:0] sumY;

  frame_tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .FRAME_HZ (FRAME_HZ)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick_o (frameTick)
  );

  assign lastPix = (pixIdx_q == LAST_IDX);

  // Square walker is row-major; ERASE walks the old position, DRAW the new one.
  always_comb begin
    baseX    = (state_q == SEQ_ERASE) ? oldX_q : newX_q;
    baseY    = (state_q == SEQ_ERASE) ? oldY_q : newY_q;
    offX     = pixIdx_q % SIDE;
    offY     = pixIdx_q / SIDE;
    sumX     = {1'b0, baseX} + {5'b0, offX};
    sumY     = {1'b0, baseY} + {4'b0, offY};
    x_d      = sumX[7:0];
    y_d      = sumY[6:0];
    colour_d = (state_q == SEQ_ERASE) ? BG_COLOUR : newColour_q;
    plot_d   = 1'b0;
    case (state_q)
      SEQ_ERASE, SEQ_DRAW: plot_d = onScreen(sumX, sumY);
      SEQ_COLS: begin
        x_d      = bus.col_x;
        y_d      = bus.col_y;
        colour_d = bus.col_colour;
        plot_d   = bus.col_valid && onScreen({1'b0, bus.col_x}, {1'b0, bus.col_y});
      end
      default: plot_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= SEQ_IDLE;
      pixIdx_q    <= '0;
      newX_q      <= '0;
      newY_q      <= '0;
      newColour_q <= '0;
      oldX_q      <= '0;
      oldY_q      <= '0;
      oldValid_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
    end else begin
      plot_q <= plot_d;
      if (plot_d) begin
        x_q      <= x_d;
        y_q      <= y_d;
        colour_q <= colour_d;
      end
      case (state_q)
        SEQ_IDLE: begin
          if (frameTick) state_q <= SEQ_LATCH;
        end
        SEQ_LATCH: begin
          newX_q      <= bus.dot_x;
          newY_q      <= bus.dot_y;
          newColour_q <= bus.dot_colour;
          pixIdx_q    <= '0;
          state_q     <= oldValid_q ? SEQ_ERASE : SEQ_DRAW;
        end
        SEQ_ERASE: begin
          if (lastPix) begin
            pixIdx_q <= '0;
            state_q  <= SEQ_DRAW;
          end else begin
            pixIdx_q <= pixIdx_q + 4'd1;
          end
        end
        SEQ_DRAW: begin
          if (lastPix) begin
            pixIdx_q   <= '0;
            oldX_q     <= newX_q;
            oldY_q     <= newY_q;
            oldValid_q <= 1'b1;
            state_q    <= SEQ_COLS;
          end else begin
            pixIdx_q <= pixIdx_q + 4'd1;
          end
        end
        SEQ_COLS: begin
          if (bus.col_done) state_q <= SEQ_IDLE;
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = colour_q;
  assign bus.plot       = plot_q;
  assign bus.col_ready  = (state_q == SEQ_COLS);
  assign bus.busy       = (state_q != SEQ_IDLE);
  assign bus.frame_tick = frameTick;
  assign bus.overrun    = frameTick && (state_q != SEQ_IDLE);

endmodule
